ahblite_dma_master: RTL and testbench
=====================================

Name: ahblite_dma_master

Overview:
- AHB-Lite initiator (master) that copies a block of 32-bit words from a source address range to a destination address range.
- Each word is moved as one single read transfer followed by one single write transfer.
- Drives the master-side AHB-Lite signal set into the interconnect, i.e. the request end of the existing decoder/slave-mux fabric, and completes data phases against its HREADY/HRESP/HRDATA returns.
- A simple command port (start pulse plus configuration) launches a job; busy/done/error report progress.

Parameters:
- CNT_W, 16: width of the word-count field; maximum job length is 2^CNT_W-1 words.

Ports:
- HCLK  input  1  bus clock; all state updates on its rising edge
- HRESETn  input  1  asynchronous, active-low reset
- START  input  1  one-cycle job launch pulse; sampled only in IDLE
- SRC_ADDR  input  32  source byte address; bits [1:0] ignored (treated as 0)
- DST_ADDR  input  32  destination byte address; bits [1:0] ignored
- WORD_CNT  input  CNT_W  number of words to copy
- FILL_MODE  input  1  fill-mode select (only with DMA_FILL_EN)
- FILL_VALUE  input  32  fill word (only with DMA_FILL_EN)
- BUSY  output  1  high from the cycle after an accepted START until DONE
- DONE  output  1  one-cycle pulse at job end, normal or aborted
- ERROR  output  1  sticky; set on HRESP=1; cleared by the next accepted START
- HADDR  output  32  transfer address
- HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
- HWRITE  output  1  1=write
- HSIZE  output  3  constant 3'b010 (word)
- HBURST  output  3  constant 3'b000 (SINGLE)
- HPROT  output  4  constant 4'b0011
- HMASTLOCK  output  1  constant 0
- HWDATA  output  32  write data, valid in the write data phase
- HREADY  input  1  transfer-done from the slave mux
- HRDATA  input  32  read data
- HRESP  input  1  1=ERROR response

Behaviour:
- Reset (asynchronous, any state, including mid-job):
  - state=IDLE; HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
  - BUSY=0, DONE=0, ERROR=0.
  - All counters and registers cleared.
- Internal registers: src_ptr[31:0], dst_ptr[31:0], remaining[CNT_W-1:0], buf[31:0].
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FIN.
- IDLE:
  - START=1 and WORD_CNT!=0: latch {SRC_ADDR[31:2],2'b00}, {DST_ADDR[31:2],2'b00} and WORD_CNT; clear ERROR; set BUSY; go to RD_ADDR.
  - START=1 and WORD_CNT=0: go to FIN with no bus activity; ERROR is cleared.
  - START outside IDLE is ignored.
- RD_ADDR:
  - Drive HTRANS=NONSEQ, HWRITE=0, HADDR=src_ptr.
  - Hold all address-phase signals stable while HREADY=0.
  - On HREADY=1: go to RD_DATA.
- RD_DATA:
  - Drive HTRANS=IDLE (no pipelined overlap).
  - On HREADY=1 with HRESP=0: buf<=HRDATA; go to WR_ADDR.
  - On HREADY=1 with HRESP=1: ERROR<=1; go to FIN.
- WR_ADDR:
  - Drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst_ptr.
  - On HREADY=1: go to WR_DATA.
- WR_DATA:
  - Drive HTRANS=IDLE and HWDATA=buf; HWDATA is held for the whole data phase.
  - On HREADY=1 with HRESP=1: ERROR<=1; go to FIN.
  - On HREADY=1 otherwise: src_ptr+=4, dst_ptr+=4 (mod 2^32, wrap permitted); remaining-=1.
    - Go to FIN if remaining was 1, else to RD_ADDR.
- FIN: DONE=1 for exactly one cycle; BUSY=0 in the same cycle; return to IDLE.
- Two-cycle ERROR response: the master may see HRESP=1 with HREADY=0; that cycle is ignored. The first cycle of a two-cycle error response causes no early action; the abort is taken on the HREADY=1 cycle.
- Throughput with zero-wait-state slaves: 4 cycles per word. Latency from START to the first NONSEQ: 1 cycle.
- HADDR is not required to hold its value in IDLE-drive cycles; it keeps the last address.

Optional Feature:
- Macro: DMA_FILL_EN.
- Defined: when FILL_MODE=1 at an accepted START, the block latches FILL_VALUE into buf and skips RD_ADDR/RD_DATA. Sequence is WR_ADDR -> WR_DATA -> WR_ADDR ..., giving 2 cycles/word. src_ptr is unused.
- Not defined: FILL_MODE and FILL_VALUE are ignored (ports remain, unconnected internally); every job is a copy.

Test Plan:
- Copy, zero wait states: SRC=0x2000_0000, DST=0x2000_0100, CNT=3, memory model holds 0x11,0x22,0x33. Expect 3 reads then 3 writes alternating R/W; dst holds 0x11,0x22,0x33. DONE pulses 12 cycles after first NONSEQ, ERROR=0.
- Wait states: slave inserts 2 HREADY=0 cycles on every data phase, CNT=2. HADDR/HTRANS/HWRITE remain stable throughout, HWDATA is held, data is correct, and no extra transfers are issued.
- Error abort: CNT=4; slave returns a two-cycle ERROR on the 2nd read. No write is issued for word 2, ERROR=1, DONE pulses once, and 1 word has been written. A following START with CNT=1 clears ERROR.
- Zero count / ignored START: START with CNT=0 gives a DONE pulse 1 cycle later with HTRANS never NONSEQ. A START pulsed mid-job has no effect on addresses or count.
- Async reset mid-job: assert HRESETn=0 during WR_ADDR. HTRANS=IDLE and BUSY=0 immediately, without a clock edge. After release, a new job runs correctly.
- DMA_FILL_EN: FILL_MODE=1, FILL_VALUE=0xDEAD_BEEF, DST=0x2000_0200, CNT=4. Expect 4 writes only (no reads), at 0x...200/204/208/20C, all data 0xDEAD_BEEF, taking 8 cycles.

Source files
------------

// File: rtl/ahblite_dma_master.sv
// AHB-Lite word-copy DMA initiator: one SINGLE read then one SINGLE write per word.
// Define DMA_FILL_EN to enable fill mode (FILL_VALUE written, no reads).
module ahblite_dma_master #(
   parameter int CNT_W = 16
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             START,
   input  logic [31:0]      SRC_ADDR,
   input  logic [31:0]      DST_ADDR,
   input  logic [CNT_W-1:0] WORD_CNT,
   input  logic             FILL_MODE,
   input  logic [31:0]      FILL_VALUE,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERROR,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   input  logic [31:0]      HRDATA,
   input  logic             HRESP
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_FIN
   } state_t;

   localparam logic [1:0]       TR_IDLE   = 2'b00;
   localparam logic [1:0]       TR_NONSEQ = 2'b10;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;

   state_t             r_state;
   logic [31:0]        r_src;
   logic [31:0]        r_dst;
   logic [CNT_W-1:0]   r_rem;
   logic [31:0]        r_buf;
   logic               r_fill;
   logic [1:0]         r_htrans;
   logic [31:0]        r_haddr;
   logic               r_hwrite;
   logic [31:0]        r_hwdata;
   logic               r_busy;
   logic               r_done;
   logic               r_error;

   logic               w_fill_req;
   logic [31:0]        w_fill_val;
   logic [31:0]        w_src_nxt;
   logic [31:0]        w_dst_nxt;

`ifdef DMA_FILL_EN
   assign w_fill_req = FILL_MODE;
   assign w_fill_val = FILL_VALUE;
`else
   logic               w_unused;
   assign w_fill_req = 1'b0;
   assign w_fill_val = 32'h0;
   assign w_unused   = ^{FILL_MODE, FILL_VALUE};
`endif

   assign w_src_nxt = r_src + 32'd4;
   assign w_dst_nxt = r_dst + 32'd4;

   assign HTRANS    = r_htrans;
   assign HADDR     = r_haddr;
   assign HWRITE    = r_hwrite;
   assign HWDATA    = r_hwdata;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign ERROR     = r_error;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_rem    <= '0;
         r_buf    <= '0;
         r_fill   <= 1'b0;
         r_htrans <= TR_IDLE;
         r_haddr  <= '0;
         r_hwrite <= 1'b0;
         r_hwdata <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_error <= 1'b0;
                  if (WORD_CNT != '0) begin
                     r_src    <= {SRC_ADDR[31:2], 2'b00};
                     r_dst    <= {DST_ADDR[31:2], 2'b00};
                     r_rem    <= WORD_CNT;
                     r_fill   <= w_fill_req;
                     r_busy   <= 1'b1;
                     r_htrans <= TR_NONSEQ;
                     if (w_fill_req) begin
                        r_buf    <= w_fill_val;
                        r_haddr  <= {DST_ADDR[31:2], 2'b00};
                        r_hwrite <= 1'b1;
                        r_state  <= S_WR_ADDR;
                     end else begin
                        r_haddr  <= {SRC_ADDR[31:2], 2'b00};
                        r_hwrite <= 1'b0;
                        r_state  <= S_RD_ADDR;
                     end
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end
               end
            end
            S_RD_ADDR: begin
               if (HREADY) begin
                  r_htrans <= TR_IDLE;
                  r_state  <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (HREADY) begin
                  if (HRESP) begin
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_buf    <= HRDATA;
                     r_htrans <= TR_NONSEQ;
                     r_haddr  <= r_dst;
                     r_hwrite <= 1'b1;
                     r_state  <= S_WR_ADDR;
                  end
               end
            end
            S_WR_ADDR: begin
               if (HREADY) begin
                  r_htrans <= TR_IDLE;
                  r_hwdata <= r_buf;
                  r_state  <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (HREADY) begin
                  if (HRESP) begin
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_src <= w_src_nxt;
                     r_dst <= w_dst_nxt;
                     r_rem <= r_rem - CNT_ONE;
                     if (r_rem == CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                     end else if (r_fill) begin
                        // buffer still holds the fill word; go straight to the next write
                        r_htrans <= TR_NONSEQ;
                        r_haddr  <= w_dst_nxt;
                        r_hwrite <= 1'b1;
                        r_state  <= S_WR_ADDR;
                     end else begin
                        r_htrans <= TR_NONSEQ;
                        r_haddr  <= w_src_nxt;
                        r_hwrite <= 1'b0;
                        r_state  <= S_RD_ADDR;
                     end
                  end
               end
            end
            S_FIN: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Bench for ahblite_dma_master: AHB slave/memory model on the falling edge,
// scoreboard of expected writes, one task per scenario.
module tb_ahblite_dma_master;

   logic        HCLK;
   logic        HRESETn;
   logic        START;
   logic [31:0] SRC_ADDR;
   logic [31:0] DST_ADDR;
   logic [15:0] WORD_CNT;
   logic        FILL_MODE;
   logic [31:0] FILL_VALUE;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY = 1'b1;
   logic [31:0] HRDATA = 32'h0;
   logic        HRESP  = 1'b0;

   ahblite_dma_master #(.CNT_W(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .START(START),
      .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .WORD_CNT(WORD_CNT),
      .FILL_MODE(FILL_MODE), .FILL_VALUE(FILL_VALUE),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   wr_t         e;
   logic [31:0] mem [logic [31:0]];
   bit          xfer_wr[$];
   logic [31:0] xfer_addr[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int done_cnt, done_cyc, first_ns, ns_seen;
   int wr_cnt, rd_cnt, rd_idx;
   int err_rd = 0;
   int waits = 0;
   bit ap_stall_en = 0;
   logic busy_at_done;

   bit          dp_act = 0, dp_wr = 0, dp_err = 0, dp_estep = 0;
   int          dp_wait = 0;
   logic [31:0] dp_addr, dp_wd0;
   bit          ap_v = 0, ap_w = 0, ap_stalled = 0;
   logic [31:0] ap_a;

   // slave + monitor: observes bus mid-cycle, drives responses for next edge
   always @(negedge HCLK) begin
      cyc++;
      if (!HRESETn) begin
         dp_act = 0; ap_v = 0; ap_stalled = 0;
         HREADY = 1'b1; HRESP = 1'b0;
      end else begin
         if (HTRANS == 2'b10) ns_seen++;
         if (HTRANS == 2'b10 && first_ns < 0) first_ns = cyc;
         if (DONE) begin
            done_cnt++; done_cyc = cyc; busy_at_done = BUSY;
         end
         if (HREADY) begin
            dp_act = ap_v; dp_addr = ap_a; dp_wr = ap_w;
            dp_wait = waits; dp_estep = 0; dp_err = 0; ap_stalled = 0;
            if (ap_v) begin
               xfer_wr.push_back(ap_w);
               xfer_addr.push_back(ap_a);
               if (!ap_w) begin
                  rd_idx++;
                  dp_err = (rd_idx == err_rd);
               end
               dp_wd0 = HWDATA;
            end
            ap_v = 0;
         end else begin
            if (ap_v) begin
               checks++;
               if (HTRANS !== 2'b10 || HADDR !== ap_a || HWRITE !== ap_w) begin
                  errors++;
                  $display("FAIL addr_hold got %b/%h/%b want 10/%h/%b",
                           HTRANS, HADDR, HWRITE, ap_a, ap_w);
               end
            end
            if (dp_act && dp_wr) begin
               checks++;
               if (HWDATA !== dp_wd0) begin
                  errors++;
                  $display("FAIL wdata_hold got %h want %h", HWDATA, dp_wd0);
               end
            end
         end
         HRESP = 1'b0;
         if (dp_act) begin
            if (dp_err) begin
               HRESP = 1'b1;
               HREADY = dp_estep;
               dp_estep = 1;
            end else if (dp_wait > 0) begin
               HREADY = 1'b0;
               dp_wait--;
            end else begin
               HREADY = 1'b1;
               if (dp_wr) begin
                  mem[dp_addr] = HWDATA;
                  wr_cnt++;
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL sb_unexpected_write addr %h data %h", dp_addr, HWDATA);
                  end else begin
                     e = sb.pop_front();
                     if (dp_addr !== e.a || HWDATA !== e.d) begin
                        errors++;
                        $display("FAIL sb_write got %h:%h want %h:%h",
                                 dp_addr, HWDATA, e.a, e.d);
                     end
                  end
               end else begin
                  HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : 32'h0;
                  rd_cnt++;
               end
            end
         end else begin
            HREADY = 1'b1;
            if (HTRANS == 2'b10) begin
               if (ap_stall_en && !ap_stalled) begin
                  HREADY = 1'b0;
                  ap_stalled = 1;
               end
               ap_v = 1; ap_a = HADDR; ap_w = HWRITE;
            end
         end
      end
   end

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         e.a = d + 32'(4 * i);
         e.d = mem[s + 32'(4 * i)];
         sb.push_back(e);
      end
   endtask

   task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input logic fm, input logic [31:0] fv);
      @(negedge HCLK);
      #1;
      done_cnt = 0; done_cyc = -1; first_ns = -1; ns_seen = 0;
      wr_cnt = 0; rd_cnt = 0; rd_idx = 0;
      xfer_wr.delete();
      xfer_addr.delete();
      SRC_ADDR = s; DST_ADDR = d; WORD_CNT = n;
      FILL_MODE = fm; FILL_VALUE = fv;
      START = 1'b1;
      t0 = cyc;
      @(negedge HCLK);
      #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string nm);
      int k;
      k = 0;
      while (done_cnt == 0 && k < lim) begin
         @(negedge HCLK);
         #1;
         k++;
      end
      if (done_cnt == 0) begin
         checks++; errors++;
         $display("FAIL %s_timeout got no DONE want DONE within %0d cycles", nm, lim);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0; START = 1'b0;
      SRC_ADDR = '0; DST_ADDR = '0; WORD_CNT = '0;
      FILL_MODE = 1'b0; FILL_VALUE = '0;
      repeat (2) @(negedge HCLK);
      #1;
      checks++;
      if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus got %b/%h/%b/%h want 00/0/0/0", HTRANS, HADDR, HWRITE, HWDATA);
      end
      checks++;
      if ({BUSY, DONE, ERROR} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status got %b want 000", {BUSY, DONE, ERROR});
      end
      checks++;
      if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
         errors++;
         $display("FAIL reset_consts got %b/%b/%b/%b want 010/000/0011/0",
                  HSIZE, HBURST, HPROT, HMASTLOCK);
      end
      HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);
   endtask

   task automatic test_copy();
      mem[32'h2000_0000] = 32'h11;
      mem[32'h2000_0004] = 32'h22;
      mem[32'h2000_0008] = 32'h33;
      push_copy(32'h2000_0000, 32'h2000_0100, 3);
      start_job(32'h2000_0000, 32'h2000_0100, 16'd3, 1'b0, 32'h0);
      checks++;
      if (BUSY !== 1'b1) begin
         errors++; $display("FAIL copy_busy got %b want 1", BUSY);
      end
      wait_done(100, "copy");
      checks++;
      if (first_ns - t0 != 1) begin
         errors++; $display("FAIL copy_start_latency got %0d want 1", first_ns - t0);
      end
      checks++;
      if (done_cyc - first_ns != 12) begin
         errors++; $display("FAIL copy_done_latency got %0d want 12", done_cyc - first_ns);
      end
      checks++;
      if (ERROR !== 1'b0 || busy_at_done !== 1'b0) begin
         errors++; $display("FAIL copy_status got err %b busy %b want 0 0", ERROR, busy_at_done);
      end
      checks++;
      if (xfer_wr.size() != 6) begin
         errors++; $display("FAIL copy_xfers got %0d want 6", xfer_wr.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            logic [31:0] ea;
            ea = ((i % 2) == 1) ? 32'h2000_0100 + 32'(4 * (i / 2))
                                : 32'h2000_0000 + 32'(4 * (i / 2));
            checks++;
            if (xfer_wr[i] !== bit'(i % 2) || xfer_addr[i] !== ea) begin
               errors++;
               $display("FAIL copy_order[%0d] got w%b@%h want w%0d@%h",
                        i, xfer_wr[i], xfer_addr[i], i % 2, ea);
            end
         end
      end
      checks++;
      if (mem[32'h2000_0100] !== 32'h11 || mem[32'h2000_0104] !== 32'h22 ||
          mem[32'h2000_0108] !== 32'h33) begin
         errors++; $display("FAIL copy_mem got %h %h %h want 11 22 33",
                            mem[32'h2000_0100], mem[32'h2000_0104], mem[32'h2000_0108]);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL copy_sb_left got %0d want 0", sb.size());
      end
   endtask

   task automatic test_wait_states();
      mem[32'h2000_0400] = 32'hA5A5_0001;
      mem[32'h2000_0404] = 32'h5A5A_0002;
      waits = 2; ap_stall_en = 1;
      push_copy(32'h2000_0400, 32'h2000_0500, 2);
      start_job(32'h2000_0400, 32'h2000_0500, 16'd2, 1'b0, 32'h0);
      wait_done(200, "wait");
      waits = 0; ap_stall_en = 0;
      checks++;
      if (xfer_wr.size() != 4 || wr_cnt != 2 || rd_cnt != 2) begin
         errors++; $display("FAIL wait_xfers got %0d (r%0d w%0d) want 4 (r2 w2)",
                            xfer_wr.size(), rd_cnt, wr_cnt);
      end
      checks++;
      if (mem[32'h2000_0500] !== 32'hA5A5_0001 || mem[32'h2000_0504] !== 32'h5A5A_0002) begin
         errors++; $display("FAIL wait_mem got %h %h want a5a50001 5a5a0002",
                            mem[32'h2000_0500], mem[32'h2000_0504]);
      end
      checks++;
      if (sb.size() != 0 || ERROR !== 1'b0) begin
         errors++; $display("FAIL wait_end got sb %0d err %b want 0 0", sb.size(), ERROR);
      end
   endtask

   task automatic test_error_abort();
      for (int i = 0; i < 4; i++) mem[32'h2000_0600 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
      err_rd = 2;
      push_copy(32'h2000_0600, 32'h2000_0700, 1);
      start_job(32'h2000_0600, 32'h2000_0700, 16'd4, 1'b0, 32'h0);
      wait_done(100, "err");
      repeat (3) @(negedge HCLK);
      #1;
      err_rd = 0;
      checks++;
      if (ERROR !== 1'b1) begin
         errors++; $display("FAIL err_flag got %b want 1", ERROR);
      end
      checks++;
      if (wr_cnt != 1 || done_cnt != 1) begin
         errors++; $display("FAIL err_counts got w%0d d%0d want w1 d1", wr_cnt, done_cnt);
      end
      checks++;
      if (xfer_wr.size() != 3 || sb.size() != 0) begin
         errors++; $display("FAIL err_xfers got %0d sb %0d want 3 sb 0", xfer_wr.size(), sb.size());
      end
      push_copy(32'h2000_0600, 32'h2000_0800, 1);
      start_job(32'h2000_0600, 32'h2000_0800, 16'd1, 1'b0, 32'h0);
      checks++;
      if (ERROR !== 1'b0) begin
         errors++; $display("FAIL err_clear got %b want 0", ERROR);
      end
      wait_done(100, "err_rerun");
      checks++;
      if (mem[32'h2000_0800] !== 32'hC0DE_0000 || ERROR !== 1'b0) begin
         errors++; $display("FAIL err_rerun got %h err %b want c0de0000 0",
                            mem[32'h2000_0800], ERROR);
      end
   endtask

   task automatic test_zero_and_ignore();
      start_job(32'h2000_0000, 32'h2000_0900, 16'd0, 1'b0, 32'h0);
      wait_done(20, "zero");
      repeat (2) @(negedge HCLK);
      #1;
      checks++;
      if (done_cyc - t0 != 1 || done_cnt != 1) begin
         errors++; $display("FAIL zero_done got lat %0d cnt %0d want 1 1", done_cyc - t0, done_cnt);
      end
      checks++;
      if (ns_seen != 0 || BUSY !== 1'b0) begin
         errors++; $display("FAIL zero_bus got ns %0d busy %b want 0 0", ns_seen, BUSY);
      end
      mem[32'h2000_0A00] = 32'h0BAD_F00D;
      mem[32'h2000_0A04] = 32'h1234_5678;
      push_copy(32'h2000_0A00, 32'h2000_0B00, 2);
      start_job(32'h2000_0A00, 32'h2000_0B00, 16'd2, 1'b0, 32'h0);
      repeat (2) @(negedge HCLK);
      #1;
      SRC_ADDR = 32'h3000_0000; DST_ADDR = 32'h3000_1000; WORD_CNT = 16'd5;
      START = 1'b1;
      @(negedge HCLK);
      #1;
      START = 1'b0;
      wait_done(100, "ignore");
      repeat (3) @(negedge HCLK);
      #1;
      checks++;
      if (xfer_wr.size() != 4 || done_cnt != 1 || sb.size() != 0) begin
         errors++; $display("FAIL ignore_xfers got %0d done %0d sb %0d want 4 1 0",
                            xfer_wr.size(), done_cnt, sb.size());
      end else begin
         checks++;
         if (xfer_addr[2] !== 32'h2000_0A04) begin
            errors++; $display("FAIL ignore_src got %h want 20000a04", xfer_addr[2]);
         end
      end
   endtask

   task automatic test_async_reset();
      int k;
      bit hit;
      mem[32'h2000_0C00] = 32'h7777_0000;
      start_job(32'h2000_0C00, 32'h2000_0D00, 16'd3, 1'b0, 32'h0);
      hit = 0; k = 0;
      while (!hit && k < 20) begin
         if (HTRANS == 2'b10 && HWRITE == 1'b1) hit = 1;
         else begin
            @(negedge HCLK);
            #1;
            k++;
         end
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL rst_find_wr_addr got none want WR_ADDR within 20 cycles");
      end
      #1;
      HRESETn = 1'b0;
      #1;
      checks++;
      if (HTRANS !== 2'b00 || BUSY !== 1'b0 || HADDR !== 32'h0) begin
         errors++; $display("FAIL rst_async got %b busy %b addr %h want 00 0 0",
                            HTRANS, BUSY, HADDR);
      end
      repeat (2) @(negedge HCLK);
      #1;
      HRESETn = 1'b1;
      sb.delete();
      mem[32'h2000_0E00] = 32'h8888_0001;
      mem[32'h2000_0E04] = 32'h8888_0002;
      push_copy(32'h2000_0E00, 32'h2000_0F00, 2);
      start_job(32'h2000_0E00, 32'h2000_0F00, 16'd2, 1'b0, 32'h0);
      wait_done(100, "rst_rerun");
      checks++;
      if (wr_cnt != 2 || sb.size() != 0 || mem[32'h2000_0F04] !== 32'h8888_0002) begin
         errors++; $display("FAIL rst_rerun got w%0d sb %0d last %h want w2 sb0 88880002",
                            wr_cnt, sb.size(), mem[32'h2000_0F04]);
      end
   endtask

   task automatic test_fill();
      mem[32'h2000_1000] = 32'h4444_0001;
      mem[32'h2000_1004] = 32'h4444_0002;
      mem[32'h2000_1008] = 32'h4444_0003;
      mem[32'h2000_100C] = 32'h4444_0004;
`ifdef DMA_FILL_EN
      for (int i = 0; i < 4; i++) begin
         e.a = 32'h2000_0200 + 32'(4 * i);
         e.d = 32'hDEAD_BEEF;
         sb.push_back(e);
      end
`else
      push_copy(32'h2000_1000, 32'h2000_0200, 4);
`endif
      start_job(32'h2000_1000, 32'h2000_0200, 16'd4, 1'b1, 32'hDEAD_BEEF);
      wait_done(100, "fill");
      checks++;
      if (wr_cnt != 4 || sb.size() != 0) begin
         errors++; $display("FAIL fill_writes got w%0d sb %0d want w4 sb0", wr_cnt, sb.size());
      end
`ifdef DMA_FILL_EN
      checks++;
      if (rd_cnt != 0 || xfer_wr.size() != 4) begin
         errors++; $display("FAIL fill_no_reads got r%0d x%0d want r0 x4", rd_cnt, xfer_wr.size());
      end
      checks++;
      if (done_cyc - first_ns != 8) begin
         errors++; $display("FAIL fill_cycles got %0d want 8", done_cyc - first_ns);
      end
`else
      checks++;
      if (rd_cnt != 4 || done_cyc - first_ns != 16) begin
         errors++; $display("FAIL fill_ignored got r%0d cyc %0d want r4 cyc16",
                            rd_cnt, done_cyc - first_ns);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_copy();
      test_wait_states();
      test_error_abort();
      test_zero_and_ignore();
      test_async_reset();
      test_fill();
      repeat (2) @(negedge HCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
